mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_WAIT, default 4, consecutive D grants tolerated while I is pending (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 i_req_valid  in  1  fetch read request; i_req_addr  in  ADDR_W  fetch address; i_req_ready  out  1  fetch request accepted this cycle.
REQ-007 i_rsp_valid  out  1  fetch data valid, one-cycle pulse; i_rsp_data  out  DATA_W  fetch read data.
REQ-008 d_req_valid  in  1  load/store request; d_req_we  in  1  1=write; d_req_addr  in  ADDR_W; d_req_wdata  in  DATA_W; d_req_be  in  DATA_W/8; d_req_ready  out  1  accepted this cycle.
REQ-009 d_rsp_valid  out  1  load data or store ack, one-cycle pulse; d_rsp_data  out  DATA_W  load data (0 for stores).
REQ-010 m_req_valid  out  1; m_req_we  out  1; m_req_addr  out  ADDR_W; m_req_wdata  out  DATA_W; m_req_be  out  DATA_W/8; m_req_ready  in  1  memory accepts request.
REQ-011 m_rsp_valid  in  1  memory response (reads and writes); m_rsp_data  in  DATA_W.
REQ-012 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-013 Block SHALL share one memory port between fetch (I) and data (D) requesters, one transaction outstanding at a time.
REQ-014 FSM states: IDLE, REQ, WAIT; owner register (I/D) and captured request fields held from IDLE exit to WAIT exit.
REQ-015 IDLE: if any request is valid, the winner's *_req_ready SHALL be high combinationally that cycle, its fields are captured, owner set, next state REQ; the loser's ready stays low.
REQ-016 Arbitration: D wins over I when both are valid, subject to REQ-027.
REQ-017 REQ: m_req_valid=1 with captured fields (m_req_we=0, m_req_be=all-ones for I); on m_req_ready=1 go to WAIT; fields SHALL be stable while m_req_ready=0.
REQ-018 WAIT: on m_rsp_valid=1 the owner's *_rsp_valid SHALL pulse for exactly one cycle on the following cycle with m_rsp_data registered (d_rsp_data forced 0 for writes); FSM returns to IDLE on the same edge.
REQ-019 Minimum request-to-response: accept at cycle 0, m_req_valid at 1, earliest m_rsp_valid at 2, *_rsp_valid at 3; next acceptance possible at cycle 3 (overlapping the rsp pulse).
REQ-020 m_rsp_valid outside WAIT, including the same cycle as m_req_ready in REQ, SHALL be ignored.
REQ-021 *_req_ready SHALL be 0 in REQ and WAIT; requesters may drop valid before acceptance without effect.
REQ-022 i_rsp_valid and d_rsp_valid SHALL never be high in the same cycle.
REQ-023 Outputs are registered except *_req_ready.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, clear owner, captured fields, starvation counter, and all response registers.
REQ-025 Reset values: m_req_valid=0, m_req_we=0, m_req_addr=0, m_req_wdata=0, m_req_be=0, i_rsp_valid=0, d_rsp_valid=0, rsp data=0, busy=0; *_req_ready=0 while rst=1.
REQ-026 Reset mid-transaction SHALL drop it: no rsp pulse is emitted, and a late m_rsp_valid after reset is ignored per REQ-020.

Configuration
REQ-027 With ARB_STARVE_GUARD_EN defined: a 4-bit counter increments on each D grant made while i_req_valid=1, clears on every I grant; when counter==MAX_WAIT and both valid, I SHALL win.
REQ-028 Without ARB_STARVE_GUARD_EN: counter absent, strict D priority always.

Verification
REQ-029 I only, addr 0x100, m_req_ready same cycle, m_rsp_valid 1 cycle later with 0xDEADBEEF -> i_rsp_valid at cycle 3, i_rsp_data=0xDEADBEEF, busy low at cycle 3.
REQ-030 I and D valid together, D write 0x200/0x12345678/be=0xF -> d_req_ready first, m_req_we=1 and m_req_be=0xF, d_rsp_valid with data 0; then I served next.
REQ-031 m_req_ready held 0 for 5 cycles in REQ -> m_req_addr/wdata/be unchanged; m_rsp_valid pulsed during REQ ignored.
REQ-032 Guard enabled, MAX_WAIT=4, D and I continuously valid -> grant sequence D,D,D,D,I,D,...; guard disabled -> I never granted.
REQ-033 rst asserted in WAIT, then m_rsp_valid -> no i/d_rsp_valid pulse, FSM IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D) requesters, one access in flight.
// Optional starvation guard for fetch: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_req_ready,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                m_req_valid,
    output logic                m_req_we,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_be,
    input  logic                m_req_ready,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state, state_nxt;
    logic   owner_d;
    logic   grant_i, grant_d;
    logic   starve;
    logic   rsp_take;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;

    // D grants while I waits; at the limit I takes the next slot
    assign starve = i_req_valid && (wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (grant_i) begin
            wait_cnt <= '0;
        end else if (grant_d && i_req_valid) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    if (d_req_valid && !starve) grant_d = 1'b1;
                    else if (i_req_valid)       grant_i = 1'b1;
                    if (grant_d || grant_i) state_nxt = REQ;
                end
            end
            REQ:     if (m_req_ready) state_nxt = WAIT;
            WAIT:    if (m_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign busy        = (state != IDLE);
    assign rsp_take    = (state == WAIT) && m_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d     <= 1'b0;
            m_req_valid <= 1'b0;
            m_req_we    <= 1'b0;
            m_req_addr  <= '0;
            m_req_wdata <= '0;
            m_req_be    <= '0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
        end else begin
            if (grant_d) begin
                owner_d     <= 1'b1;
                m_req_valid <= 1'b1;
                m_req_we    <= d_req_we;
                m_req_addr  <= d_req_addr;
                m_req_wdata <= d_req_wdata;
                m_req_be    <= d_req_be;
            end else if (grant_i) begin
                owner_d     <= 1'b0;
                m_req_valid <= 1'b1;
                m_req_we    <= 1'b0;
                m_req_addr  <= i_req_addr;
                m_req_wdata <= '0;
                m_req_be    <= '1;
            end else if (state == REQ && m_req_ready) begin
                m_req_valid <= 1'b0;
            end
            i_rsp_valid <= rsp_take && !owner_d;
            d_rsp_valid <= rsp_take && owner_d;
            if (rsp_take) begin
                if (owner_d) d_rsp_data <= m_req_we ? '0 : m_rsp_data;
                else         i_rsp_data <= m_rsp_data;
            end
        end
    end
endmodule
